// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Purpose:
//   Multi-ported register file for the pipelined ARM datapath. It has two
//   combinational read ports, two write ports and a per-register busy
//   scoreboard.
//   - Write port 0 carries ALU writeback.
//   - Write port 1 carries load/memory return. When both write ports target
//     the same register on the same edge, port 1 wins.
//   - Decode uses the scoreboard to detect RAW hazards on destinations that
//     are still in flight.
//   - Register ZERO_REG always reads 0. It is never written, never busy and
//     always ready.
//
// Configuration macro:
//   REGFILE_MP_BYPASS_EN
//     When defined, a write that is in flight is forwarded to a matching read
//     port in the same cycle, and that read reports ready. When undefined,
//     reads return stored contents and ready reflects the busy bit only.
//
// Parameters:
//   WIDTH     data width of every register and bus
//   DEPTH     number of registers (power of two, >= 2)
//   ZERO_REG  index hardwired to zero
//   AW        address width, derived from DEPTH
//
// Ports:
//   Clk      in   1      clock, rising edge
//   ResetN   in   1      asynchronous active-low reset; clears data and busy
//   RA, RB   in   AW     read addresses
//   BusA/B   out  WIDTH  read data
//   ReadyA/B out  1      read register is not busy (or is forwarded)
//   RW0/BusW0/RegWr0  in  write port 0 (ALU)
//   RW1/BusW1/RegWr1  in  write port 1 (load), higher priority
//   RAlloc/AllocWr    in  mark a destination busy
//   BusyVec  out  DEPTH  scoreboard, bit i = register i busy
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic             ReadyA,
    output logic             ReadyB,
    input  logic [AW-1:0]    RW0,
    input  logic [WIDTH-1:0] BusW0,
    input  logic             RegWr0,
    input  logic [AW-1:0]    RW1,
    input  logic [WIDTH-1:0] BusW1,
    input  logic             RegWr1,
    input  logic [AW-1:0]    RAlloc,
    input  logic             AllocWr,
    output logic [DEPTH-1:0] BusyVec
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic             w_commit0;
    logic             w_commit1;
    logic             w_alloc;
    logic [DEPTH-1:0] w_busy_next;
    logic [WIDTH-1:0] w_bus_a;
    logic [WIDTH-1:0] w_bus_b;
    logic             w_rdy_a;
    logic             w_rdy_b;

    // Write qualification. Port 0 is dropped when port 1 commits to the same
    // register, so the load return always lands last.
    always_comb begin
        w_commit1 = RegWr1 && (RW1 != ZR);
        w_commit0 = RegWr0 && (RW0 != ZR) && !(w_commit1 && (RW1 == RW0));
        w_alloc   = AllocWr && (RAlloc != ZR);
    end

    // Scoreboard next state. Alloc is applied after the write clears, so a
    // same-edge alloc and write to one register leaves it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_commit0) begin
            w_busy_next[RW0] = 1'b0;
        end
        if (w_commit1) begin
            w_busy_next[RW1] = 1'b0;
        end
        if (w_alloc) begin
            w_busy_next[RAlloc] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_commit0) begin
                r_mem[RW0] <= BusW0;
            end
            if (w_commit1) begin
                r_mem[RW1] <= BusW1;
            end
            r_busy <= w_busy_next;
        end
    end

    // Read ports. The zero register masks both data and readiness, so its
    // storage and busy contents never reach the outputs.
    always_comb begin
        w_bus_a = (RA == ZR) ? '0 : r_mem[RA];
        w_bus_b = (RB == ZR) ? '0 : r_mem[RB];
        w_rdy_a = !r_busy[RA] || (RA == ZR);
        w_rdy_b = !r_busy[RB] || (RB == ZR);
`ifdef REGFILE_MP_BYPASS_EN
        // Forward in-flight writes. Port 1 is checked first so it wins. A
        // forwarded read is ready even if the register is being allocated on
        // the same edge, because the data on the bus is already valid.
        if (RA != ZR) begin
            if (RegWr1 && (RW1 == RA)) begin
                w_bus_a = BusW1;
                w_rdy_a = 1'b1;
            end else if (RegWr0 && (RW0 == RA)) begin
                w_bus_a = BusW0;
                w_rdy_a = 1'b1;
            end
        end
        if (RB != ZR) begin
            if (RegWr1 && (RW1 == RB)) begin
                w_bus_b = BusW1;
                w_rdy_b = 1'b1;
            end else if (RegWr0 && (RW0 == RB)) begin
                w_bus_b = BusW0;
                w_rdy_b = 1'b1;
            end
        end
`endif
    end

    assign BusA    = w_bus_a;
    assign BusB    = w_bus_b;
    assign ReadyA  = w_rdy_a;
    assign ReadyB  = w_rdy_b;
    assign BusyVec = r_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write 64-bit register file for the pipelined ARM datapath.
- Generalised width, depth and hardwired-zero index.
- Adds a second write port for the load/memory return path, with defined priority.
- Adds an async active-low reset that clears all state, and a per-register busy scoreboard so decode can detect RAW hazards on long-latency destinations.

Parameters:
- WIDTH, 64, data width of every register and bus.
- DEPTH, 32, number of registers; power of two, minimum 2.
- ZERO_REG, 31, index hardwired to read 0; writes and allocs to it are ignored.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- ResetN  in  1  async active-low reset.
- RA  in  AW  read address, port A.
- RB  in  AW  read address, port B.
- BusA  out  WIDTH  read data, port A.
- BusB  out  WIDTH  read data, port B.
- ReadyA  out  1  register RA holds committed/forwarded data (not busy).
- ReadyB  out  1  same, for RB.
- RW0  in  AW  write address, port 0 (ALU writeback).
- BusW0  in  WIDTH  write data, port 0.
- RegWr0  in  1  write enable, port 0.
- RW1  in  AW  write address, port 1 (load writeback).
- BusW1  in  WIDTH  write data, port 1.
- RegWr1  in  1  write enable, port 1.
- RAlloc  in  AW  destination to mark busy.
- AllocWr  in  1  alloc enable.
- BusyVec  out  DEPTH  scoreboard bits, bit i = register i busy.

Behaviour:
- Clocking: one clock (Clk). Reset is asynchronous and active-low (ResetN): assertion immediately clears every register to 0 and every busy bit to 0, regardless of Clk. Deassertion is synchronised externally. Reset asserted mid-operation discards pending writes and allocs that cycle.
- Outputs after reset: BusA = BusB = 0, ReadyA = ReadyB = 1, BusyVec = 0.
- Reads: combinational, zero latency. BusX = registers[RX]; BusX = 0 whenever RX == ZERO_REG.
- Writes:
  - Committed on rising Clk when RegWrN = 1 and RWN != ZERO_REG.
  - Both ports to different addresses: both commit.
  - Both ports to the same address: port 1 (load) wins, port 0 is discarded.
- Scoreboard:
  - Rising edge with AllocWr = 1 and RAlloc != ZERO_REG sets busy[RAlloc].
  - Any committed write (either port) to register i clears busy[i].
  - Alloc and write to the same register in the same cycle: alloc wins, busy stays/becomes 1, data still written.
  - Alloc of an already-busy register: stays busy, no error.
  - Writes to non-busy registers are legal and leave busy at 0.
- Ready: ReadyX = !busy[RX] | (RX == ZERO_REG), modified by the bypass rule under the Optional Feature.
- Write latency: data visible on the BusX read of the cycle after the committing edge (zero cycles with bypass).
- No internal storage beyond DEPTH×WIDTH data plus DEPTH busy bits.
- ZERO_REG never busy, never written, always ready.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Same-cycle forwarding. If RegWrN = 1, RWN == RX and RX != ZERO_REG, BusX = BusWN combinationally; port 1 takes priority if both match.
  - ReadyX is forced to 1 for a read that is being forwarded.
  - Forwarding is not suppressed by a same-cycle alloc to that register, because ready reflects the forwarded data.
- Undefined:
  - No forwarding; reads return stored contents until after the edge.
  - ReadyX reflects busy only.

Test Plan:
- Reset: write 0xDEAD to R3, then pulse ResetN low mid-cycle (not on an edge) -> BusA with RA=3 reads 0 immediately, BusyVec = 0, ReadyA = 1.
- Dual write: RW0=5/BusW0=0x11 and RW1=6/BusW1=0x22 in the same edge -> R5=0x11, R6=0x22. Then both ports to R7 with 0xAA/0xBB -> R7=0xBB.
- Zero register: RegWr0 to R31 with 0xFFFF plus AllocWr to R31 -> RA=31 gives BusA=0, ReadyA=1, BusyVec[31]=0.
- Scoreboard: alloc R9 -> ReadyB=0 with RB=9, BusyVec=0x200. Port-1 write of 0x1234 to R9 -> next cycle ReadyB=1, BusB=0x1234. Alloc and write of R9 in the same edge -> busy stays 1.
- Bypass (macro defined): RA=4, RegWr0 to R4 with 0x55 in the same cycle -> BusA=0x55 before the edge. Undefined -> old R4 value until after the edge.
- Parameter sweep: WIDTH=32, DEPTH=16, ZERO_REG=0 -> R0 reads 0, write to R15 with 0xFFFFFFFF reads back exactly, BusyVec width 16.
